// File: rtl/pkt_buffer_writer_if.sv
// Port bundle of the packet buffer writer: RX flit stream, emptylist pop port,
// buffer write port, metadata output and statistics counters.
interface pkt_buffer_writer_if #(
  parameter int PKT_AWIDTH = 9
);
  localparam int PKTBUF_AWIDTH = PKT_AWIDTH + 5;

  logic                     in_pkt_sop;
  logic                     in_pkt_eop;
  logic                     in_pkt_valid;
  logic [511:0]             in_pkt_data;
  logic [5:0]               in_pkt_empty;
  logic [2:0]               in_pkt_flags;
  logic                     in_pkt_ready;

  logic [PKT_AWIDTH-1:0]    emptylist_out_data;
  logic                     emptylist_out_valid;
  logic                     emptylist_out_ready;

  // writedata packs {data[511:0], sop, eop, empty[5:0]}
  logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
  logic                     pkt_buffer_write;
  logic [519:0]             pkt_buffer_writedata;

  // meta_data packs {pkt_id, flits[4:0], len[15:0], pkt_flags[2:0]}
  logic                     meta_valid;
  logic [PKT_AWIDTH+23:0]   meta_data;
  logic                     meta_ready;

  logic [31:0]              pkt_cnt;
  logic [31:0]              drop_cnt;
  logic [31:0]              err_cnt;

  modport master (
    input  in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_data, in_pkt_empty, in_pkt_flags,
    output in_pkt_ready,
    input  emptylist_out_data, emptylist_out_valid,
    output emptylist_out_ready,
    output pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
    output meta_valid, meta_data,
    input  meta_ready,
    output pkt_cnt, drop_cnt, err_cnt
  );

  modport slave (
    output in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_data, in_pkt_empty, in_pkt_flags,
    input  in_pkt_ready,
    output emptylist_out_data, emptylist_out_valid,
    input  emptylist_out_ready,
    input  pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
    input  meta_valid, meta_data,
    output meta_ready,
    input  pkt_cnt, drop_cnt, err_cnt
  );
endinterface

// File: rtl/pkt_buffer_writer.sv
// Receive side of the packet buffer: allocates a slot per packet from the
// emptylist, writes flits into the slot and emits one metadata record per packet.
module pkt_buffer_writer #(
  parameter int PKT_AWIDTH = 9,
  parameter int MAX_FLITS  = 31
) (
  input logic                 clk,
  input logic                 rst_n,
  pkt_buffer_writer_if.master bus
);
  localparam int PKTBUF_AWIDTH = PKT_AWIDTH + 5;
  localparam logic [2:0]  PKT_DROP = 3'b100;
  localparam logic [4:0]  MAX_IDX  = 5'(MAX_FLITS);
  localparam logic [15:0] DROP_LEN = 16'(64 * MAX_FLITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [4:0]            flits;
    logic [15:0]           len;
    logic [2:0]            pkt_flags;
  } metadata_t;

  function automatic logic [15:0] calc_len(input logic [4:0] flits, input logic [5:0] empty);
    return {5'd0, flits, 6'd0} - {10'd0, empty};
  endfunction

  state_t                   state_r, state_s;
  logic [PKT_AWIDTH-1:0]    pkt_id_r, pkt_id_s;
  logic [2:0]               flags_r, flags_s;
  logic [4:0]               idx_r, idx_s;
  logic                     run_r;

  logic                     ready_s, accept_s, pop_s, meta_hold_s;
  logic                     wr_en_s, emit_s, err_inc_s, drop_inc_s;
  logic [PKTBUF_AWIDTH-1:0] wr_addr_s;
  metadata_t                meta_s;

  logic                     wr_r;
  logic [PKTBUF_AWIDTH-1:0] addr_r;
  flit_t                    writedata_r;
  logic                     meta_valid_r;
  metadata_t                meta_data_r;
  logic [31:0]              pkt_cnt_r, drop_cnt_r, err_cnt_r;

  // Next-state, handshake and write/emit decisions for the packet FSM
  always_comb begin
    state_s     = state_r;
    pkt_id_s    = pkt_id_r;
    flags_s     = flags_r;
    idx_s       = idx_r;
    ready_s     = 1'b0;
    pop_s       = 1'b0;
    wr_en_s     = 1'b0;
    wr_addr_s   = {PKTBUF_AWIDTH{1'b0}};
    emit_s      = 1'b0;
    meta_s      = '0;
    err_inc_s   = 1'b0;
    drop_inc_s  = 1'b0;
    meta_hold_s = meta_valid_r & ~bus.meta_ready;

    case (state_r)
      IDLE: begin
        ready_s = run_r & bus.emptylist_out_valid & ~meta_hold_s;
      end
      WRITE, DISCARD: begin
        ready_s = run_r & ~meta_hold_s;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
    accept_s = ready_s & bus.in_pkt_valid;

    case (state_r)
      IDLE: begin
        if (accept_s && bus.in_pkt_sop) begin
          pop_s     = 1'b1;
          pkt_id_s  = bus.emptylist_out_data;
          flags_s   = bus.in_pkt_flags;
          idx_s     = 5'd1;
          wr_en_s   = 1'b1;
          wr_addr_s = {bus.emptylist_out_data, 5'd0};
          if (bus.in_pkt_eop) begin
            emit_s = 1'b1;
            meta_s = '{pkt_id: bus.emptylist_out_data, flits: 5'd1,
                       len: calc_len(5'd1, bus.in_pkt_empty), pkt_flags: bus.in_pkt_flags};
          end else begin
            state_s = WRITE;
          end
        end else if (accept_s) begin
          err_inc_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (accept_s && bus.in_pkt_sop) begin
          // a new sop aborts the open packet; the sop beat itself is dropped
          emit_s    = 1'b1;
          meta_s    = '{pkt_id: pkt_id_r, flits: idx_r, len: {5'd0, idx_r, 6'd0}, pkt_flags: PKT_DROP};
          err_inc_s = 1'b1;
          state_s   = IDLE;
        end else if (accept_s && (idx_r == MAX_IDX)) begin
          if (bus.in_pkt_eop) begin
            emit_s     = 1'b1;
            meta_s     = '{pkt_id: pkt_id_r, flits: MAX_IDX, len: DROP_LEN, pkt_flags: PKT_DROP};
            drop_inc_s = 1'b1;
            state_s    = IDLE;
          end else begin
            state_s = DISCARD;
          end
        end else if (accept_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {pkt_id_r, idx_r};
          idx_s     = idx_r + 5'd1;
          if (bus.in_pkt_eop) begin
            emit_s  = 1'b1;
            meta_s  = '{pkt_id: pkt_id_r, flits: idx_r + 5'd1,
                        len: calc_len(idx_r + 5'd1, bus.in_pkt_empty), pkt_flags: flags_r};
            state_s = IDLE;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DISCARD: begin
        if (accept_s && bus.in_pkt_eop) begin
          emit_s     = 1'b1;
          meta_s     = '{pkt_id: pkt_id_r, flits: MAX_IDX, len: DROP_LEN, pkt_flags: PKT_DROP};
          drop_inc_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and per-packet context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pkt_id_r <= {PKT_AWIDTH{1'b0}};
      flags_r  <= 3'd0;
      idx_r    <= 5'd0;
      run_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      pkt_id_r <= pkt_id_s;
      flags_r  <= flags_s;
      idx_r    <= idx_s;
      run_r    <= 1'b1;
    end
  end

  // Registered buffer write port, one cycle behind beat acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r        <= 1'b0;
      addr_r      <= {PKTBUF_AWIDTH{1'b0}};
      writedata_r <= '0;
    end else if (wr_en_s) begin
      wr_r        <= 1'b1;
      addr_r      <= wr_addr_s;
      writedata_r <= '{data: bus.in_pkt_data, sop: bus.in_pkt_sop,
                       eop: bus.in_pkt_eop, empty: bus.in_pkt_empty};
    end else begin
      wr_r        <= 1'b0;
    end
  end

  // One-deep metadata register; a new record may load in the draining cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_valid_r <= 1'b0;
      meta_data_r  <= '0;
    end else if (emit_s) begin
      meta_valid_r <= 1'b1;
      meta_data_r  <= meta_s;
    end else if (meta_valid_r && bus.meta_ready) begin
      meta_valid_r <= 1'b0;
    end else begin
      meta_valid_r <= meta_valid_r;
    end
  end

  // Statistics counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_r  <= 32'd0;
      drop_cnt_r <= 32'd0;
      err_cnt_r  <= 32'd0;
    end else begin
      pkt_cnt_r  <= pkt_cnt_r  + {31'd0, meta_valid_r & bus.meta_ready};
      drop_cnt_r <= drop_cnt_r + {31'd0, drop_inc_s};
      err_cnt_r  <= err_cnt_r  + {31'd0, err_inc_s};
    end
  end

  assign bus.in_pkt_ready         = ready_s;
  assign bus.emptylist_out_ready  = pop_s;
  assign bus.pkt_buffer_address   = addr_r;
  assign bus.pkt_buffer_write     = wr_r;
  assign bus.pkt_buffer_writedata = writedata_r;
  assign bus.meta_valid           = meta_valid_r;
  assign bus.meta_data            = meta_data_r;
  assign bus.pkt_cnt              = pkt_cnt_r;
  assign bus.drop_cnt             = drop_cnt_r;
  assign bus.err_cnt              = err_cnt_r;

endmodule

// File: doc/pkt_buffer_writer.md
Name: pkt_buffer_writer

Overview:
- Receive side of the on-chip packet buffer.
- Accepts the classified Ethernet RX flit stream, allocates a packet slot ID (pktID) from the packet emptylist, and writes each flit to `(pktID << 5) + flit index`.
- On end-of-packet, emits one metadata_t record per packet toward the data mover.
- The data mover reads the flits back and returns the pktID to the emptylist.

Parameters:
- PKT_AWIDTH, 9: pktID width; slots = 2^PKT_AWIDTH.
- PKTBUF_AWIDTH, PKT_AWIDTH+5: buffer flit address width (32 flits per slot).
- MAX_FLITS, 31: maximum flits stored per packet (fits metadata flits field, 5 bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_pkt_sop  in  1  first flit.
- in_pkt_eop  in  1  last flit.
- in_pkt_valid  in  1  beat valid.
- in_pkt_data  in  512  flit payload.
- in_pkt_empty  in  6  unused bytes in eop flit.
- in_pkt_flags  in  3  PKT_PCIE/PKT_ETH/PKT_DROP class, sampled on sop beat.
- in_pkt_ready  out  1  beat accepted when valid&ready.
- emptylist_out_data  in  PKT_AWIDTH  free pktID (show-ahead).
- emptylist_out_valid  in  1  free pktID available.
- emptylist_out_ready  out  1  pop strobe.
- pkt_buffer_address  out  PKTBUF_AWIDTH  write address.
- pkt_buffer_write  out  1  write strobe.
- pkt_buffer_writedata  out  flit_t  {data, sop, eop, empty}.
- meta_valid  out  1  metadata valid.
- meta_data  out  metadata_t  {pktID, flits, len, pkt_flags}.
- meta_ready  in  1  metadata accepted.
- pkt_cnt  out  32  packets emitted.
- drop_cnt  out  32  packets emitted as PKT_DROP due to overflow.
- err_cnt  out  32  protocol violations.

Behaviour:
- Reset (rst_n low, async): state IDLE. Output reset values:
  - in_pkt_ready, emptylist_out_ready, pkt_buffer_write, meta_valid: 0.
  - pkt_buffer_address, meta_data, all counters: 0.
  - A pktID popped before a mid-packet reset is lost; system reset also reinitialises the emptylist.
- meta_hold = meta_valid & !meta_ready (one-deep metadata register occupied and not draining).
- State IDLE:
  - in_pkt_ready = emptylist_out_valid & !meta_hold.
  - Accepted sop beat: emptylist_out_ready pulses combinationally in the same cycle. Latch pktID and flags, set flit index to 1, go to WRITE. If eop is also set, emit metadata and stay in IDLE.
  - Accepted non-sop beat: discarded, err_cnt+1, no pop.
- State WRITE:
  - in_pkt_ready = !meta_hold.
  - Each accepted beat is written at `{pktID,5'b0} + index`, and index increments.
  - Eop beat: emit metadata, go to IDLE.
  - Sop beat: current packet closes as PKT_DROP (metadata emitted with the flits written so far), err_cnt+1, and the beat is discarded.
  - Accepted non-eop beat when index == MAX_FLITS: beat not written, go to DISCARD.
- State DISCARD:
  - in_pkt_ready = !meta_hold; beats are consumed without writes.
  - On eop: emit metadata with pkt_flags = PKT_DROP, flits = MAX_FLITS; drop_cnt+1; go to IDLE.
- Write path: registered, 1-cycle latency from acceptance to pkt_buffer_write. sop/eop/empty are copied into writedata.
- Metadata:
  - meta_valid is asserted in the same cycle as the eop flit's pkt_buffer_write.
  - Held stable until meta_ready; pkt_cnt+1 on handshake.
  - len = 64*flits − empty on the eop flit, 16-bit. Drops report len = 64*MAX_FLITS.
  - Only PKT_DROP overrides in_pkt_flags.
- Simultaneous meta_ready and a new eop completion: the register reloads in the same cycle with no bubble.
- Throughput: back-to-back single-flit packets at 1/cycle when emptylist_out_valid and meta_ready are held high.
- Counters wrap modulo 2^32.
- Assertion: emptylist_out_ready never asserted while emptylist_out_valid is low.

Test Plan:
- Single 60-byte packet (sop=eop=1, empty=4, flags=PKT_PCIE), emptylist head 0 -> write addr 0 one cycle later; meta {pktID 0, flits 1, len 60, PCIE}; pkt_cnt 1.
- 150-byte 3-flit packet, head pktID 5 -> writes to 160, 161, 162, last with empty 42; meta flits 3, len 150.
- 40-flit packet -> 31 writes (addr pktID*32+0..30); meta flags PKT_DROP, flits 31, len 1984; drop_cnt 1; all 40 beats consumed.
- emptylist_out_valid low for 10 cycles with a sop pending -> in_pkt_ready low, no writes; accepted on the first cycle valid rises.
- meta_ready held low after packet A, packet B's sop pending -> in_pkt_ready low, meta A stable; releasing meta_ready accepts B next cycle.
- Reset asserted mid-packet (flit 2 of 4) -> outputs zero asynchronously; after release, a non-sop beat increments err_cnt and a fresh packet completes normally.
